// File: rtl/spi_host_pkg.sv
// -----------------------------------------------------------------------------
// spi_host_pkg
// Shared definitions for the SPI word host: default frame/timing constants,
// FSM state encodings and small constant helpers.
// -----------------------------------------------------------------------------
package spi_host_pkg;

  // Default frame geometry and CS timing (all in clk cycles).
  localparam int WORD_BITS_DEF = 64;
  localparam int SCK_DIV_DEF   = 4;
  localparam int CS_SETUP_DEF  = 2;
  localparam int CS_HOLD_DEF   = 2;
  localparam int CS_IDLE_DEF   = 4;

  // FSM state encodings.
  typedef logic [2:0] state_t;
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETUP    = 3'd1;
  localparam logic [2:0] ST_SHIFT_LO = 3'd2;
  localparam logic [2:0] ST_SHIFT_HI = 3'd3;
  localparam logic [2:0] ST_HOLD     = 3'd4;
  localparam logic [2:0] ST_GAP      = 3'd5;

  // Largest of three values; sizes the shared CS wait counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // True for every state in which chip select is asserted.
  function automatic logic in_frame(input state_t s);
    return (s == ST_SETUP) || (s == ST_SHIFT_LO) ||
           (s == ST_SHIFT_HI) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// -----------------------------------------------------------------------------
// spi_sck_gen
// Half-period counter for the SPI clock. While run_i is high it counts
// SCK_DIV cycles per phase, strobes phase_end_o on the last cycle of each
// phase and toggles the registered SCK level on that edge. With run_i low the
// counter and SCK are held at zero, so every run starts with a full low phase.
//
// Ports:
//   clk          system clock
//   resetn       asynchronous active-low reset
//   run_i        high while the host is in a shift phase
//   phase_end_o  high on the last cycle of the current half-period
//   sck_o        registered SCK level (idle low)
// -----------------------------------------------------------------------------
module spi_sck_gen #(
  parameter int SCK_DIV = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic run_i,
  output logic phase_end_o,
  output logic sck_o
);

  localparam int            CW       = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;

  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!run_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      sck_d = ~sck_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign phase_end_o = run_i && (cnt_q == CNT_LAST);
  assign sck_o       = sck_q;

endmodule

// File: rtl/spi_word_host.sv
// -----------------------------------------------------------------------------
// spi_word_host
// Mode-0 SPI controller: one full-duplex WORD_BITS-bit word per chip-select
// frame, MSB first. tx_data is latched on accept; the reply captured from CIPO
// is presented on rx_data with a one-cycle rx_valid pulse when CS rises.
// SCK_DIV must be >= 2 (CIPO synchronizer latency), the CS timings >= 1.
//
// Ports:
//   clk, resetn        system clock, asynchronous active-low reset
//   tx_data, tx_valid  word to send and its request
//   tx_ready           high in IDLE; accept on tx_valid && tx_ready
//   rx_data, rx_valid  captured reply and its one-cycle update strobe
//   busy               high whenever the host is not IDLE
//   SCK, CS, COPI      SPI outputs (SCK idle low, CS active low)
//   CIPO               SPI input, asynchronous to clk
// -----------------------------------------------------------------------------
module spi_word_host
  import spi_host_pkg::*;
#(
  parameter int WORD_BITS = WORD_BITS_DEF,
  parameter int SCK_DIV   = SCK_DIV_DEF,
  parameter int CS_SETUP  = CS_SETUP_DEF,
  parameter int CS_HOLD   = CS_HOLD_DEF,
  parameter int CS_IDLE   = CS_IDLE_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [WORD_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [WORD_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 SCK,
  output logic                 CS,
  output logic                 COPI,
  input  logic                 CIPO
);

  localparam int            BW         = $clog2(WORD_BITS) + 1;
  localparam int            WAIT_MAX   = max3(CS_SETUP, CS_HOLD, CS_IDLE);
  localparam int            WW         = $clog2(WAIT_MAX) + 1;
  localparam logic [WW-1:0] SETUP_LAST = WW'(CS_SETUP - 1);
  localparam logic [WW-1:0] HOLD_LAST  = WW'(CS_HOLD - 1);
  localparam logic [WW-1:0] IDLE_LAST  = WW'(CS_IDLE - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(WORD_BITS - 1);

  state_t                 state_q, state_d;
  logic [WW-1:0]          wait_q, wait_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [WORD_BITS-1:0]   tx_sh_q, tx_sh_d;
  logic [WORD_BITS-1:0]   rx_sh_q, rx_sh_d;
  logic [WORD_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   cs_q, cs_d;
  logic                   copi_q, copi_d;
  logic                   cipo_meta_q, cipo_sync_q;
  logic                   sck_run;
  logic                   phase_end;
  logic                   sck_level;

  assign sck_run = (state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI);

  spi_sck_gen #(
    .SCK_DIV (SCK_DIV)
  ) u_sck_gen (
    .clk         (clk),
    .resetn      (resetn),
    .run_i       (sck_run),
    .phase_end_o (phase_end),
    .sck_o       (sck_level)
  );

  // Two-flop synchronizer for the asynchronous peripheral data line.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cipo_meta_q <= 1'b0;
      cipo_sync_q <= 1'b0;
    end else begin
      cipo_meta_q <= CIPO;
      cipo_sync_q <= cipo_meta_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    bit_cnt_d  = bit_cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        wait_d    = '0;
        if (tx_valid) begin
          tx_sh_d = tx_data;
          rx_sh_d = '0;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (wait_q == SETUP_LAST) begin
          wait_d  = '0;
          state_d = ST_SHIFT_LO;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      ST_SHIFT_LO: begin
        if (phase_end) begin
          state_d = ST_SHIFT_HI;
        end
      end

      // End of the high phase: capture CIPO, present the next COPI bit as
      // SCK falls on the same edge.
      ST_SHIFT_HI: begin
        if (phase_end) begin
          rx_sh_d   = {rx_sh_q[WORD_BITS-2:0], cipo_sync_q};
          tx_sh_d   = {tx_sh_q[WORD_BITS-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = (bit_cnt_q == LAST_BIT) ? ST_HOLD : ST_SHIFT_LO;
        end
      end

      ST_HOLD: begin
        if (wait_q == HOLD_LAST) begin
          wait_d     = '0;
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
          state_d    = ST_GAP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (wait_q == IDLE_LAST) begin
          wait_d  = '0;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // CS and COPI are registered from next-state values so the pins change
    // on the same edge as the state, free of decode glitches.
    cs_d   = ~in_frame(state_d);
    copi_d = in_frame(state_d) ? tx_sh_d[WORD_BITS-1] : 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      wait_q     <= '0;
      bit_cnt_q  <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      cs_q       <= 1'b1;
      copi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      cs_q       <= cs_d;
      copi_q     <= copi_d;
    end
  end

  assign tx_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign SCK      = sck_level;
  assign CS       = cs_q;
  assign COPI     = copi_q;

endmodule

// File: tb/tb_spi_word_host.sv
// -----------------------------------------------------------------------------
// tb_spi_word_host
// Two hosts: index 0 with default timing, index 1 with SCK_DIV=2 and a
// peripheral that updates CIPO late in the SCK low phase. One negedge process
// plays the peripheral and checks every DUT output against a frame-timing
// model derived from the accept cycle.
// -----------------------------------------------------------------------------
module tb_spi_word_host;

  localparam int NI    = 2;
  localparam int WB    = 64;
  localparam int SETUP = 2;
  localparam int HOLD  = 2;
  localparam int GAPC  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic          resetn   [NI];
  logic          tx_valid [NI];
  logic [WB-1:0] tx_data  [NI];
  logic          tx_ready [NI];
  logic [WB-1:0] rx_data  [NI];
  logic          rx_valid [NI];
  logic          busy     [NI];
  logic          sck      [NI];
  logic          cs       [NI];
  logic          copi     [NI];
  logic          cipo     [NI];
  logic [WB-1:0] resp     [NI];

  spi_word_host u_dut0 (
    .clk(clk), .resetn(resetn[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
    .busy(busy[0]), .SCK(sck[0]), .CS(cs[0]), .COPI(copi[0]), .CIPO(cipo[0])
  );

  spi_word_host #(.SCK_DIV(2)) u_dut1 (
    .clk(clk), .resetn(resetn[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
    .busy(busy[1]), .SCK(sck[1]), .CS(cs[1]), .COPI(copi[1]), .CIPO(cipo[1])
  );

  function automatic void check(input string name, input logic [63:0] got,
                                input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // Model state
  logic          act   [NI];
  int            t0    [NI];
  logic [WB-1:0] w     [NI];
  logic [WB-1:0] r     [NI];
  logic [WB-1:0] exp_rx[NI];
  int            nrv   [NI];
  // Peripheral state and frame measurements
  logic [WB-1:0] resp_cur[NI], cap[NI], periph_rx[NI], periph_prev[NI];
  logic          cs_prev[NI], sck_prev[NI], copi_prev[NI], pend[NI];
  int nfall[NI], rises[NI], cs_low_cnt[NI], gap_cnt[NI], hi_run[NI], last_rise[NI];
  int hi_min[NI], hi_max[NI], per_min[NI], per_max[NI];
  int last_cs_low[NI], last_rises[NI], last_hi_min[NI], last_hi_max[NI];
  int last_per_min[NI], last_per_max[NI], last_gap[NI];

  initial begin
    for (int i = 0; i < NI; i++) begin
      act[i] = 1'b0; t0[i] = 0; w[i] = '0; r[i] = '0; exp_rx[i] = '0; nrv[i] = 0;
      resp_cur[i] = '0; cap[i] = '0; periph_rx[i] = '0; periph_prev[i] = '0;
      cs_prev[i] = 1'b1; sck_prev[i] = 1'b0; copi_prev[i] = 1'b0; pend[i] = 1'b0;
      nfall[i] = 0; rises[i] = 0; cs_low_cnt[i] = 0; gap_cnt[i] = 0; hi_run[i] = 0;
      last_rise[i] = 0; hi_min[i] = 0; hi_max[i] = 0; per_min[i] = 0; per_max[i] = 0;
      last_cs_low[i] = 0; last_rises[i] = 0; last_hi_min[i] = 0; last_hi_max[i] = 0;
      last_per_min[i] = 0; last_per_max[i] = 0; last_gap[i] = 0;
      cipo[i] = 1'b0;
    end
  end

  always @(negedge clk) begin : model_and_periph
    int d, rel, p, k, cs_low_len, last_rel;
    logic cs_e, sck_e, copi_e, busy_e, rv_e;
    for (int i = 0; i < NI; i++) begin
      d          = (i == 0) ? 4 : 2;
      cs_low_len = SETUP + 2 * d * WB + HOLD;
      last_rel   = cs_low_len + GAPC;

      // ---------------- peripheral ----------------
      if (rx_valid[i] === 1'b1) nrv[i]++;
      if (cs[i]) begin
        if (!cs_prev[i]) begin
          if (rises[i] == WB) begin
            periph_prev[i] = periph_rx[i];
            periph_rx[i]   = cap[i];
          end
          last_cs_low[i] = cs_low_cnt[i];  last_rises[i]   = rises[i];
          last_hi_min[i] = hi_min[i];      last_hi_max[i]  = hi_max[i];
          last_per_min[i] = per_min[i];    last_per_max[i] = per_max[i];
          gap_cnt[i] = 0;
        end
        gap_cnt[i]++;
        resp_cur[i] = resp[i];
        cipo[i]     = resp[i][WB-1];
        nfall[i]    = 0;
        pend[i]     = 1'b0;
      end else begin
        if (cs_prev[i]) begin
          last_gap[i] = gap_cnt[i];
          cs_low_cnt[i] = 0; rises[i] = 0; cap[i] = '0; hi_run[i] = 0;
          hi_min[i] = 1000; hi_max[i] = 0; per_min[i] = 1000; per_max[i] = 0;
        end
        cs_low_cnt[i]++;
        if (pend[i]) begin
          cipo[i] = (nfall[i] < WB) ? resp_cur[i][WB-1-nfall[i]] : 1'b0;
          pend[i] = 1'b0;
        end
        if (sck[i] && !sck_prev[i]) begin
          rises[i]++;
          cap[i] = {cap[i][WB-2:0], copi[i]};
          if (rises[i] > 1) begin
            if (cyc - last_rise[i] < per_min[i]) per_min[i] = cyc - last_rise[i];
            if (cyc - last_rise[i] > per_max[i]) per_max[i] = cyc - last_rise[i];
          end
          last_rise[i] = cyc;
          hi_run[i] = 0;
          check("copi_stable_at_rise", copi[i], copi_prev[i]);
        end
        if (sck[i] && sck_prev[i]) check("copi_stable_high", copi[i], copi_prev[i]);
        if (sck[i]) hi_run[i]++;
        if (!sck[i] && sck_prev[i]) begin
          if (hi_run[i] < hi_min[i]) hi_min[i] = hi_run[i];
          if (hi_run[i] > hi_max[i]) hi_max[i] = hi_run[i];
          nfall[i]++;
          if (i == 0) cipo[i] = (nfall[i] < WB) ? resp_cur[i][WB-1-nfall[i]] : 1'b0;
          else        pend[i] = 1'b1;
        end
      end
      cs_prev[i] = cs[i]; sck_prev[i] = sck[i]; copi_prev[i] = copi[i];

      // ---------------- output model and comparison ----------------
      if (!resetn[i]) begin
        act[i]    = 1'b0;
        exp_rx[i] = '0;
        check("rst_cs", cs[i], 1'b1);
        check("rst_sck", sck[i], 1'b0);
        check("rst_copi", copi[i], 1'b0);
        check("rst_rx_valid", rx_valid[i], 1'b0);
        check("rst_busy", busy[i], 1'b0);
        check("rst_rx_data", rx_data[i], '0);
      end else begin
        if (act[i] && (cyc - t0[i]) > last_rel) act[i] = 1'b0;
        rel    = cyc - t0[i];
        busy_e = act[i] && rel >= 1 && rel <= last_rel;
        cs_e   = !(act[i] && rel >= 1 && rel <= cs_low_len);
        p      = rel - 1 - SETUP;
        sck_e  = act[i] && p >= 0 && p < 2 * d * WB && ((p / d) % 2 == 1);
        copi_e = 1'b0;
        if (!cs_e) begin
          k = (p < 0) ? 0 : p / (2 * d);
          if (k < WB) copi_e = w[i][WB-1-k];
        end
        rv_e = act[i] && rel == cs_low_len + 1;
        if (rv_e) exp_rx[i] = r[i];
        check("cs", cs[i], cs_e);
        check("sck", sck[i], sck_e);
        check("copi", copi[i], copi_e);
        check("busy", busy[i], busy_e);
        check("tx_ready", tx_ready[i], !busy_e);
        check("rx_valid", rx_valid[i], rv_e);
        check("rx_data", rx_data[i], exp_rx[i]);
        if (!busy_e && tx_valid[i]) begin
          act[i] = 1'b1; t0[i] = cyc; w[i] = tx_data[i]; r[i] = resp[i];
        end
      end
    end
  end

  task automatic send(input int i, input logic [WB-1:0] word, output int t_acc);
    tx_valid[i] = 1'b1;
    tx_data[i]  = word;
    t_acc = -1;
    for (int n = 0; n < 2000 && t_acc < 0; n++) begin
      @(negedge clk);
      if (tx_ready[i]) t_acc = cyc;
      @(posedge clk);
      #1;
    end
    if (t_acc < 0) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_rx(input int i, output int t_rv);
    t_rv = -1;
    for (int n = 0; n < 3000 && t_rv < 0; n++) begin
      @(negedge clk);
      if (rx_valid[i]) t_rv = cyc;
    end
    if (t_rv < 0) check("rx_valid_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    int ta, ta2, tr, nrv_snap, hit;
    for (int i = 0; i < NI; i++) begin
      resetn[i] = 1'b1; tx_valid[i] = 1'b0; tx_data[i] = '0; resp[i] = '0;
    end
    #2;
    resetn[0] = 1'b0; resetn[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn[0] = 1'b1; resetn[1] = 1'b1;

    // Idle after reset: no activity, no rx_valid
    repeat (1000) @(posedge clk);
    #1;
    check("idle_rx_valid_count0", nrv[0], 0);
    check("idle_rx_valid_count1", nrv[1], 0);
    check("idle_tx_ready", tx_ready[0], 1'b1);

    // Single word, reply, frame timing
    resp[0] = 64'hA5A5_5A5A_0F0F_F0F0;
    send(0, 64'h0100_0000_0000_0001, ta);
    tx_valid[0] = 1'b0;
    tx_data[0]  = 64'hDEAD_BEEF_DEAD_BEEF;
    wait_rx(0, tr);
    check("rx_valid_cycle_after_accept", tr - ta, 517);
    check("rx_data_word", rx_data[0], 64'hA5A5_5A5A_0F0F_F0F0);
    check("periph_rx_word", periph_rx[0], 64'h0100_0000_0000_0001);
    check("cs_low_cycles", last_cs_low[0], 516);
    check("sck_rises", last_rises[0], 64);
    check("sck_high_min", last_hi_min[0], 4);
    check("sck_high_max", last_hi_max[0], 4);
    check("sck_period_min", last_per_min[0], 8);
    check("sck_period_max", last_per_max[0], 8);

    // Back-to-back frames with tx_valid held high
    resp[0] = 64'h0123_4567_89AB_CDEF;
    send(0, 64'hFE00_0000_0000_0000, ta);
    send(0, 64'h0300_0000_0000_0028, ta2);
    tx_valid[0] = 1'b0;
    check("accept_to_accept", ta2 - ta, 521);
    wait_rx(0, tr);
    check("b2b_cs_high_gap", last_gap[0], 5);
    check("b2b_periph_first", periph_prev[0], 64'hFE00_0000_0000_0000);
    check("b2b_periph_second", periph_rx[0], 64'h0300_0000_0000_0028);
    check("b2b_rx_data", rx_data[0], 64'h0123_4567_89AB_CDEF);

    // Reset during SCK rise 30
    resp[0] = 64'hFFFF_0000_FFFF_0000;
    send(0, 64'h8000_0000_0000_0001, ta);
    tx_valid[0] = 1'b0;
    hit = 0;
    for (int n = 0; n < 2000 && hit == 0; n++) begin
      @(negedge clk);
      #1;
      if (rises[0] >= 30) hit = 1;
    end
    check("rise30_reached", hit, 1);
    nrv_snap = nrv[0];
    resetn[0] = 1'b0;
    #1;
    check("midrst_cs", cs[0], 1'b1);
    check("midrst_sck", sck[0], 1'b0);
    check("midrst_copi", copi[0], 1'b0);
    check("midrst_busy", busy[0], 1'b0);
    repeat (2) @(posedge clk);
    #1;
    resetn[0] = 1'b1;
    check("midrst_rx_data_cleared", rx_data[0], '0);
    resp[0] = 64'h0F1E_2D3C_4B5A_6978;
    send(0, 64'h1357_9BDF_2468_ACE0, ta);
    tx_valid[0] = 1'b0;
    wait_rx(0, tr);
    check("after_rst_rx_valid_count", nrv[0] - nrv_snap, 1);
    check("after_rst_rx_data", rx_data[0], 64'h0F1E_2D3C_4B5A_6978);
    check("after_rst_periph_rx", periph_rx[0], 64'h1357_9BDF_2468_ACE0);

    // SCK_DIV=2 host, peripheral updating late in the low phase
    resp[1] = 64'hC3C3_3C3C_9669_6996;
    send(1, 64'h0123_4567_89AB_CDEF, ta);
    tx_valid[1] = 1'b0;
    wait_rx(1, tr);
    check("div2_rx_valid_cycle", tr - ta, 261);
    check("div2_rx_data", rx_data[1], 64'hC3C3_3C3C_9669_6996);
    check("div2_periph_rx", periph_rx[1], 64'h0123_4567_89AB_CDEF);
    check("div2_cs_low_cycles", last_cs_low[1], 260);
    check("div2_sck_high_max", last_hi_max[1], 2);

    repeat (10) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
